// File: rtl/audio_dac_serializer.sv
// I2S serializer for a stereo audio DAC: one-deep hold buffer feeding
// left/right shift registers, with BCLK/LRCK generated from the system clock.
module audio_dac_serializer #(
  parameter int AUDIO_DATA_WIDTH = 24,
  parameter int BCLK_HALF_PERIOD = 8,
  parameter int SLOT_BITS        = 32
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [AUDIO_DATA_WIDTH-1:0] left_data,
  input  logic [AUDIO_DATA_WIDTH-1:0] right_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic                        aud_bclk,
  output logic                        aud_daclrck,
  output logic                        aud_dacdat,
  output logic                        frame_start,
  output logic                        underrun
);

  localparam int W  = AUDIO_DATA_WIDTH;
  localparam int DW = (BCLK_HALF_PERIOD > 1) ? $clog2(BCLK_HALF_PERIOD) : 1;
  localparam int BW = $clog2(2 * SLOT_BITS);

  localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_HALF_PERIOD - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(2 * SLOT_BITS - 1);
  localparam logic [BW-1:0] SLOT_N   = BW'(SLOT_BITS);
  localparam logic [BW-1:0] DAT_LAST = BW'(AUDIO_DATA_WIDTH);

  logic [DW-1:0] div_q, div_d;
  logic [BW-1:0] bit_q, bit_d;
  logic          bclk_q, bclk_d;
  logic          lrck_q, lrck_d;
  logic          dat_q, dat_d;
  logic          fs_q, fs_d;
  logic          ur_q, ur_d;
  logic          rdy_q, rdy_d;
  logic          full_q, full_d;
  logic [W-1:0]  hold_l_q, hold_l_d;
  logic [W-1:0]  hold_r_q, hold_r_d;
  logic [W-1:0]  sh_l_q, sh_l_d;
  logic [W-1:0]  sh_r_q, sh_r_d;
  logic [W-1:0]  last_l_q, last_l_d;
  logic [W-1:0]  last_r_q, last_r_d;

  logic          tc, fall, bnd, xfer, rslot;
  logic [BW-1:0] slot;

  always_comb begin
    tc       = (div_q == DIV_LAST);
    fall     = tc && bclk_q;
    bnd      = fall && (bit_q == BIT_LAST);
    xfer     = in_valid && rdy_q;
    div_d    = tc ? '0 : div_q + 1'b1;
    bclk_d   = tc ? ~bclk_q : bclk_q;
    bit_d    = bit_q;
    lrck_d   = lrck_q;
    dat_d    = dat_q;
    sh_l_d   = sh_l_q;
    sh_r_d   = sh_r_q;
    last_l_d = last_l_q;
    last_r_d = last_r_q;
    hold_l_d = hold_l_q;
    hold_r_d = hold_r_q;
    full_d   = full_q;
    rslot    = 1'b0;
    slot     = '0;

    if (fall) begin
      bit_d  = bnd ? '0 : bit_q + 1'b1;
      rslot  = (bit_d >= SLOT_N);
      slot   = rslot ? bit_d - SLOT_N : bit_d;
      lrck_d = rslot;
      dat_d  = 1'b0;
      if (bnd) begin
        // An empty hold buffer means the previous pair is replayed.
        if (full_q) begin
          sh_l_d   = hold_l_q;
          sh_r_d   = hold_r_q;
          last_l_d = hold_l_q;
          last_r_d = hold_r_q;
        end else begin
          sh_l_d = last_l_q;
          sh_r_d = last_r_q;
        end
      end else if (slot != '0 && slot <= DAT_LAST) begin
        if (rslot) begin
          dat_d  = sh_r_q[W-1];
          sh_r_d = sh_r_q << 1;
        end else begin
          dat_d  = sh_l_q[W-1];
          sh_l_d = sh_l_q << 1;
        end
      end
    end

    if (bnd) full_d = 1'b0;
    if (xfer) begin
      full_d   = 1'b1;
      hold_l_d = left_data;
      hold_r_d = right_data;
    end

    rdy_d = ~full_d;
    fs_d  = bnd;
    ur_d  = bnd && !full_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      div_q    <= '0;
      bit_q    <= BIT_LAST;
      bclk_q   <= 1'b0;
      lrck_q   <= 1'b0;
      dat_q    <= 1'b0;
      fs_q     <= 1'b0;
      ur_q     <= 1'b0;
      rdy_q    <= 1'b0;
      full_q   <= 1'b0;
      hold_l_q <= '0;
      hold_r_q <= '0;
      sh_l_q   <= '0;
      sh_r_q   <= '0;
      last_l_q <= '0;
      last_r_q <= '0;
    end else begin
      div_q    <= div_d;
      bit_q    <= bit_d;
      bclk_q   <= bclk_d;
      lrck_q   <= lrck_d;
      dat_q    <= dat_d;
      fs_q     <= fs_d;
      ur_q     <= ur_d;
      rdy_q    <= rdy_d;
      full_q   <= full_d;
      hold_l_q <= hold_l_d;
      hold_r_q <= hold_r_d;
      sh_l_q   <= sh_l_d;
      sh_r_q   <= sh_r_d;
      last_l_q <= last_l_d;
      last_r_q <= last_r_d;
    end
  end

  assign in_ready    = rdy_q;
  assign aud_bclk    = bclk_q;
  assign aud_daclrck = lrck_q;
  assign aud_dacdat  = dat_q;
  assign frame_start = fs_q;
  assign underrun    = ur_q;

endmodule

// File: tb/tb_audio_dac_serializer.sv
// Bench for audio_dac_serializer: time-based I2S model plus directed
// literal checks on timing, bit order, hold buffer and reset behaviour.
module tb_audio_dac_serializer;

  localparam int W = 24;
  localparam int H = 8;
  localparam int S = 32;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [W-1:0] left_data, right_data;
  logic         in_valid;
  logic         rdy, bclk, lrck, dat, fs, ur;

  int checks = 0;
  int failures = 0;

  audio_dac_serializer #(
    .AUDIO_DATA_WIDTH(W),
    .BCLK_HALF_PERIOD(H),
    .SLOT_BITS(S)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .left_data(left_data),
    .right_data(right_data),
    .in_valid(in_valid),
    .in_ready(rdy),
    .aud_bclk(bclk),
    .aud_daclrck(lrck),
    .aud_dacdat(dat),
    .frame_start(fs),
    .underrun(ur)
  );

  always #5 clk = ~clk;

  // Model state: t = clk edges since reset release.
  int           t = 0;
  logic [W-1:0] cl = '0, cr = '0, hl = '0, hr = '0;
  logic         hf = 1'b0;
  logic         exp_fs = 1'b0, exp_ur = 1'b0, exp_rdy = 1'b0;
  logic         started = 1'b0;

  always @(posedge clk) begin : mdl
    logic x, bnd, hf_n;
    int   tn;
    if (!reset_n) begin
      t       <= 0;
      hf      <= 1'b0;
      cl      <= '0;
      cr      <= '0;
      hl      <= '0;
      hr      <= '0;
      exp_fs  <= 1'b0;
      exp_ur  <= 1'b0;
      exp_rdy <= 1'b0;
    end else begin
      x    = in_valid && exp_rdy;
      tn   = t + 1;
      bnd  = (tn >= 2*H) && (((tn - 2*H) % (4*H*S)) == 0);
      hf_n = hf;
      t      <= tn;
      exp_fs <= bnd;
      exp_ur <= bnd && !hf;
      if (bnd && hf) begin
        cl   <= hl;
        cr   <= hr;
        hf_n = 1'b0;
      end
      if (x) begin
        hl   <= left_data;
        hr   <= right_data;
        hf_n = 1'b1;
      end
      hf      <= hf_n;
      exp_rdy <= !hf_n;
    end
    started <= 1'b1;
  end

  function automatic logic [5:0] model_out();
    int   n, b, s;
    logic bc, lr, d;
    bc = ((t / H) % 2) == 1;
    n  = t / (2*H);
    lr = 1'b0;
    d  = 1'b0;
    if (n > 0) begin
      b  = (n - 1) % (2*S);
      lr = (b >= S);
      s  = b % S;
      if (s >= 1 && s <= W) d = lr ? cr[W-s] : cl[W-s];
    end
    return {bc, lr, d, exp_fs, exp_ur, exp_rdy};
  endfunction

  always @(negedge clk) begin
    if (started) begin
      checks++;
      if ({bclk, lrck, dat, fs, ur, rdy} !== model_out()) begin
        failures++;
        $display("FAIL model t=%0d {bclk,lrck,dat,fs,ur,rdy} got=%b want=%b",
                 t, {bclk, lrck, dat, fs, ur, rdy}, model_out());
      end
    end
  end

  task automatic chk(input string nm, input logic a, input logic e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s t=%0d got=%b want=%b", nm, t, a, e);
    end
  endtask

  task automatic chk_zero(input string nm);
    checks++;
    if ({bclk, lrck, dat, fs, ur, rdy} !== 6'b0) begin
      failures++;
      $display("FAIL %s got=%b want=000000", nm,
               {bclk, lrck, dat, fs, ur, rdy});
    end
  endtask

  task automatic wait_t(input int target);
    int g = 0;
    while (t != target && g < 20000) begin
      @(negedge clk);
      g++;
    end
    if (t != target) begin
      checks++;
      failures++;
      $display("FAIL wait_t got=%0d want=%0d", t, target);
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    in_valid   = 1'b0;
    left_data  = '0;
    right_data = '0;
    repeat (4) @(negedge clk);
    chk_zero("reset_outs");
    reset_n = 1'b1;

    // Idle start: underrun frames of zeros.
    wait_t(1);    chk("rdy_after_rel", rdy, 1'b1);
    wait_t(7);    chk("bclk_t7", bclk, 1'b0);
    wait_t(8);    chk("bclk_rise_t8", bclk, 1'b1);
    wait_t(16);   chk("fs_t16", fs, 1'b1);
                  chk("ur_t16", ur, 1'b1);
    wait_t(527);  chk("lrck_t527", lrck, 1'b0);
    wait_t(528);  chk("lrck_t528", lrck, 1'b1);
    wait_t(1040); chk("fs_t1040", fs, 1'b1);
                  chk("lrck_t1040", lrck, 1'b0);
    wait_t(1552); chk("lrck_t1552", lrck, 1'b1);

    // Fresh start with a pair pushed before the first boundary.
    reset_n = 1'b0;
    @(negedge clk);
    reset_n    = 1'b1;
    in_valid   = 1'b1;
    left_data  = 24'h800001;
    right_data = 24'h7FFFFF;
    wait_t(2);
    in_valid = 1'b0;
    chk("rdy_full", rdy, 1'b0);
    wait_t(16);  chk("fs_pair", fs, 1'b1);
                 chk("ur_pair", ur, 1'b0);
    wait_t(32);  chk("L_b1", dat, 1'b1);
    wait_t(48);  chk("L_b2", dat, 1'b0);
    wait_t(400); chk("L_b24", dat, 1'b1);
    wait_t(416); chk("L_b25", dat, 1'b0);
    wait_t(544); chk("R_b1", dat, 1'b0);
    wait_t(560); chk("R_b2", dat, 1'b1);
    wait_t(912); chk("R_b24", dat, 1'b1);
    wait_t(928); chk("R_b25", dat, 1'b0);

    // No new pairs: repeat with underrun on three boundaries.
    wait_t(1040); chk("ur_rep1", ur, 1'b1);
    wait_t(1056); chk("rep1_L_b1", dat, 1'b1);
    wait_t(2064); chk("ur_rep2", ur, 1'b1);
    wait_t(3088); chk("ur_rep3", ur, 1'b1);

    // Second pair offered while hold is full must wait.
    wait_t(3200);
    in_valid   = 1'b1;
    left_data  = 24'hA5C3F0;
    right_data = 24'h0F1E2D;
    wait_t(3201);
    left_data  = 24'h123456;
    right_data = 24'hFEDCBA;
    chk("rdy_busy1", rdy, 1'b0);
    wait_t(3500); chk("rdy_busy2", rdy, 1'b0);
    wait_t(4111); chk("rdy_busy3", rdy, 1'b0);
    wait_t(4112); chk("rdy_back", rdy, 1'b1);
                  chk("ur_p2", ur, 1'b0);
    wait_t(4113); chk("rdy_p3_taken", rdy, 1'b0);
    in_valid = 1'b0;
    wait_t(4128); chk("p2_L_b1", dat, 1'b1);
    wait_t(5152); chk("p3_L_b1", dat, 1'b0);
    wait_t(5200); chk("p3_L_b4", dat, 1'b1);
    wait_t(5664); chk("p3_R_b1", dat, 1'b1);

    // Transfer in the very boundary cycle with an empty hold buffer.
    wait_t(7183);
    in_valid   = 1'b1;
    left_data  = 24'h5A5A5A;
    right_data = 24'hC0FFEE;
    wait_t(7184);
    in_valid = 1'b0;
    chk("bnd_xfer_ur", ur, 1'b1);
    chk("bnd_xfer_rdy", rdy, 1'b0);
    wait_t(8208); chk("p4_fs", fs, 1'b1);
                  chk("p4_ur", ur, 1'b0);
    wait_t(8224); chk("p4_L_b1", dat, 1'b0);
    wait_t(8240); chk("p4_L_b2", dat, 1'b1);
    wait_t(8736); chk("p4_R_b1", dat, 1'b1);

    // Reset mid right slot aborts the frame.
    wait_t(8850);
    chk("pre_rst_lrck", lrck, 1'b1);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("midrst_outs");
    reset_n = 1'b1;
    wait_t(7);   chk("re_bclk_t7", bclk, 1'b0);
    wait_t(8);   chk("re_bclk_t8", bclk, 1'b1);
    wait_t(16);  chk("re_fs", fs, 1'b1);
                 chk("re_ur", ur, 1'b1);
    wait_t(32);  chk("re_dat0", dat, 1'b0);
    wait_t(100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
